// File: rtl/stage_mem.sv
// stage_mem: memory-access stage of the 5-stage MIPS pipeline plus the MEM/WB
// pipeline register. Performs byte/half/word loads and stores against an
// internal synchronous data RAM and registers everything StageWB consumes.
module stage_mem #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        valid_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [1:0]  memSize_in,
    input  logic        memSigned_in,
    input  logic [1:0]  MemtoReg_in,
    input  logic        RegWrite_in,
    input  logic [4:0]  writeReg_in,
    input  logic [31:0] outAlu_in,
    input  logic [31:0] writeData_in,
    input  logic [31:0] currentPC_in,
    output logic [1:0]  MemtoReg,
    output logic [31:0] readDataMem,
    output logic [31:0] outAlu,
    output logic [31:0] currentPC,
    output logic        RegWrite,
    output logic [4:0]  writeReg,
    output logic        valid_out,
    output logic        misaligned
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Data RAM; contents are deliberately not reset.
    logic [31:0] ram [DEPTH];

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            lane;
    logic                  is_byte;
    logic                  is_half;
    logic                  access;
    logic                  misaligned_now;
    logic                  store_en;
    logic [3:0]            lane_we;
    logic [31:0]           store_data;
    logic [31:0]           ram_word;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [31:0]           load_value;

    // Upper address bits are dropped so accesses wrap modulo the RAM size.
    assign word_idx = outAlu_in[ADDR_WIDTH+1:2];
    assign lane     = outAlu_in[1:0];
    assign is_byte  = (memSize_in == 2'b00);
    assign is_half  = (memSize_in == 2'b01);
    assign access   = valid_in & (MemRead_in | MemWrite_in);
    assign misaligned_now = access & ((is_half & lane[0]) |
                                      (!is_byte & !is_half & (lane != 2'b00)));
    assign store_en = valid_in & MemWrite_in & !misaligned_now & !stall & !flush;
    assign ram_word = ram[word_idx];

    // Replicate store data across lanes and pick the lanes this access touches.
    always_comb begin
        lane_we    = 4'b0000;
        store_data = writeData_in;
        if (is_byte) begin
            lane_we    = 4'b0001 << lane;
            store_data = {4{writeData_in[7:0]}};
        end else if (is_half) begin
            lane_we    = lane[1] ? 4'b1100 : 4'b0011;
            store_data = {2{writeData_in[15:0]}};
        end else begin
            lane_we    = 4'b1111;
        end
        if (!store_en) begin
            lane_we = 4'b0000;
        end
    end

    // Per-lane RAM write; an edge seen while reset is held performs no store.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_we[k]) begin
                    ram[word_idx][8*k +: 8] <= store_data[8*k +: 8];
                end
            end
        end
    end

    // Extract the addressed byte or halfword and extend it to 32 bits.
    always_comb begin
        byte_sel   = ram_word[7:0];
        half_sel   = lane[1] ? ram_word[31:16] : ram_word[15:0];
        load_value = ram_word;
        case (lane)
            2'd0:    byte_sel = ram_word[7:0];
            2'd1:    byte_sel = ram_word[15:8];
            2'd2:    byte_sel = ram_word[23:16];
            default: byte_sel = ram_word[31:24];
        endcase
        if (is_byte) begin
            load_value = memSigned_in ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
        end else if (is_half) begin
            load_value = memSigned_in ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
        end
    end

    // MEM/WB register: flush makes a bubble, stall holds, otherwise capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MemtoReg    <= 2'b00;
            readDataMem <= 32'b0;
            outAlu      <= 32'b0;
            currentPC   <= 32'b0;
            RegWrite    <= 1'b0;
            writeReg    <= 5'b0;
            valid_out   <= 1'b0;
            misaligned  <= 1'b0;
        end else if (flush) begin
            MemtoReg    <= 2'b00;
            readDataMem <= 32'b0;
            outAlu      <= 32'b0;
            currentPC   <= 32'b0;
            RegWrite    <= 1'b0;
            writeReg    <= 5'b0;
            valid_out   <= 1'b0;
            misaligned  <= 1'b0;
        end else if (!stall) begin
            MemtoReg    <= MemtoReg_in;
            readDataMem <= (MemRead_in & !misaligned_now) ? load_value : 32'b0;
            outAlu      <= outAlu_in;
            currentPC   <= currentPC_in;
            RegWrite    <= RegWrite_in & valid_in & !misaligned_now;
            writeReg    <= writeReg_in;
            valid_out   <= valid_in;
            misaligned  <= misaligned_now;
        end
    end

endmodule

// File: tb/tb_stage_mem.sv
// tb_stage_mem: randomized and directed bench for stage_mem with a
// behavioural model of the RAM and of the MEM/WB register contents.
module tb_stage_mem;

    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic        clk;
    logic        rst_n;
    logic        stall, flush, valid_in, MemRead_in, MemWrite_in, memSigned_in, RegWrite_in;
    logic [1:0]  memSize_in, MemtoReg_in;
    logic [4:0]  writeReg_in;
    logic [31:0] outAlu_in, writeData_in, currentPC_in;
    logic [1:0]  MemtoReg;
    logic [31:0] readDataMem, outAlu, currentPC;
    logic        RegWrite, valid_out, misaligned;
    logic [4:0]  writeReg;

    stage_mem #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_in(valid_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .memSize_in(memSize_in),
        .memSigned_in(memSigned_in), .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in),
        .writeReg_in(writeReg_in), .outAlu_in(outAlu_in), .writeData_in(writeData_in),
        .currentPC_in(currentPC_in), .MemtoReg(MemtoReg), .readDataMem(readDataMem),
        .outAlu(outAlu), .currentPC(currentPC), .RegWrite(RegWrite), .writeReg(writeReg),
        .valid_out(valid_out), .misaligned(misaligned)
    );

    // Model state: memory image and the expected MEM/WB contents.
    logic [31:0] ram_m [DEPTH];
    logic [1:0]  exp_memtoreg;
    logic [31:0] exp_rdata, exp_alu, exp_pc;
    logic        exp_regwrite, exp_valid, exp_mis;
    logic [4:0]  exp_wreg;
    int          checks = 0;
    int          passes = 0;
    bit          cmp_en = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    endtask

    task automatic clearExpected();
        exp_memtoreg = 0; exp_rdata = 0; exp_alu = 0; exp_pc = 0;
        exp_regwrite = 0; exp_valid = 0; exp_mis = 0; exp_wreg = 0;
    endtask

    // Compare every DUT output with the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check32("MemtoReg",    32'(MemtoReg),  32'(exp_memtoreg));
            check32("readDataMem", readDataMem,    exp_rdata);
            check32("outAlu",      outAlu,         exp_alu);
            check32("currentPC",   currentPC,      exp_pc);
            check32("RegWrite",    32'(RegWrite),  32'(exp_regwrite));
            check32("writeReg",    32'(writeReg),  32'(exp_wreg));
            check32("valid_out",   32'(valid_out), 32'(exp_valid));
            check32("misaligned",  32'(misaligned),32'(exp_mis));
        end
    end

    // Advance one clock: predict the MEM/WB contents and memory from the current inputs.
    task automatic applyStimulus();
        logic [31:0] a, w, v, nrd;
        logic [7:0]  b;
        logic [15:0] h;
        int          idx;
        bit          acc, mis, st;
        a   = outAlu_in;
        idx = int'(a[AW+1:2]);
        acc = valid_in && (MemRead_in || MemWrite_in);
        mis = acc && ((memSize_in == 2'd1 && a[0]) || (memSize_in >= 2'd2 && a[1:0] != 2'd0));
        w   = ram_m[idx];
        b   = 8'(w >> (8 * a[1:0]));
        h   = 16'(w >> (16 * a[1]));
        if (memSize_in == 2'd0)      v = memSigned_in ? {{24{b[7]}}, b} : {24'b0, b};
        else if (memSize_in == 2'd1) v = memSigned_in ? {{16{h[15]}}, h} : {16'b0, h};
        else                         v = w;
        nrd = (MemRead_in && !mis) ? v : 32'b0;
        st  = valid_in && MemWrite_in && !mis && !stall && !flush;
        if (!rst_n) clearExpected();
        @(posedge clk);
        #1;
        if (!rst_n || flush) begin
            clearExpected();
        end else if (!stall) begin
            exp_memtoreg = MemtoReg_in; exp_rdata = nrd; exp_alu = a; exp_pc = currentPC_in;
            exp_regwrite = RegWrite_in && valid_in && !mis; exp_wreg = writeReg_in;
            exp_valid = valid_in; exp_mis = mis;
        end
        if (rst_n && st) begin
            if (memSize_in == 2'd0)      ram_m[idx][8*a[1:0] +: 8] = writeData_in[7:0];
            else if (memSize_in == 2'd1) ram_m[idx][16*a[1] +: 16] = writeData_in[15:0];
            else                         ram_m[idx] = writeData_in;
        end
    endtask

    // One directed memory operation with random pass-through fields.
    task automatic doOp(input bit rd, input bit wr, input logic [1:0] size, input bit sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input bit st, input bit fl);
        valid_in = 1; MemRead_in = rd; MemWrite_in = wr; memSize_in = size; memSigned_in = sgn;
        outAlu_in = addr; writeData_in = wdata; stall = st; flush = fl; RegWrite_in = 1;
        MemtoReg_in = 2'($urandom); writeReg_in = 5'($urandom); currentPC_in = $urandom;
        applyStimulus();
    endtask

    // Literal expectation: pins both the DUT and the model to a hand-derived value.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] mdl, input logic [31:0] lit);
        check32(name, act, lit);
        check32({name, "_model"}, mdl, lit);
    endtask

    initial begin
        rst_n = 0; stall = 0; flush = 0; valid_in = 0; MemRead_in = 0; MemWrite_in = 0;
        memSize_in = 0; memSigned_in = 0; MemtoReg_in = 0; RegWrite_in = 0; writeReg_in = 0;
        outAlu_in = 0; writeData_in = 0; currentPC_in = 0;
        clearExpected();
        @(posedge clk);
        #1;
        cmp_en = 1;
        checkOutput("reset_valid", 32'(valid_out), 32'(exp_valid), 32'h0);
        rst_n = 1;

        // Fill memory so every later read has a defined value.
        for (int i = 0; i < DEPTH; i++) doOp(0, 1, 2'd2, 0, 32'(i * 4), $urandom, 0, 0);

        // Word store and load.
        doOp(0, 1, 2'd2, 0, 32'h10, 32'h12345678, 0, 0);
        valid_in = 1; MemRead_in = 1; MemWrite_in = 0; memSize_in = 2'd2; outAlu_in = 32'h10;
        MemtoReg_in = 2'b01; currentPC_in = 32'h0000_0400; RegWrite_in = 1; writeReg_in = 5'd7;
        applyStimulus();
        checkOutput("word_load", readDataMem, exp_rdata, 32'h12345678);
        checkOutput("word_regwrite", 32'(RegWrite), 32'(exp_regwrite), 32'h1);
        checkOutput("word_pc", currentPC, exp_pc, 32'h400);
        checkOutput("word_memtoreg", 32'(MemtoReg), 32'(exp_memtoreg), 32'h1);

        // Byte store, then byte and word loads.
        doOp(0, 1, 2'd0, 0, 32'h13, 32'h000000AB, 0, 0);
        doOp(1, 0, 2'd0, 1, 32'h13, 0, 0, 0);
        checkOutput("lb_signed", readDataMem, exp_rdata, 32'hFFFFFFAB);
        doOp(1, 0, 2'd0, 0, 32'h13, 0, 0, 0);
        checkOutput("lb_unsigned", readDataMem, exp_rdata, 32'h000000AB);
        doOp(1, 0, 2'd2, 0, 32'h10, 0, 0, 0);
        checkOutput("lw_after_sb", readDataMem, exp_rdata, 32'hAB345678);

        // Half loads and address aliasing.
        doOp(1, 0, 2'd1, 1, 32'h12, 0, 0, 0);
        checkOutput("lh_signed", readDataMem, exp_rdata, 32'hFFFFAB34);
        doOp(1, 0, 2'd1, 0, 32'h12, 0, 0, 0);
        checkOutput("lh_unsigned", readDataMem, exp_rdata, 32'h0000AB34);
        doOp(1, 0, 2'd2, 0, 32'h10 + 32'(4 * DEPTH), 0, 0, 0);
        checkOutput("lw_alias", readDataMem, exp_rdata, 32'hAB345678);

        // Misaligned accesses.
        doOp(0, 1, 2'd2, 0, 32'h11, 32'hDEADBEEF, 0, 0);
        checkOutput("sw_mis_flag", 32'(misaligned), 32'(exp_mis), 32'h1);
        checkOutput("sw_mis_regwrite", 32'(RegWrite), 32'(exp_regwrite), 32'h0);
        doOp(1, 0, 2'd2, 0, 32'h10, 0, 0, 0);
        checkOutput("sw_mis_mem", readDataMem, exp_rdata, 32'hAB345678);
        doOp(1, 0, 2'd1, 1, 32'h13, 0, 0, 0);
        checkOutput("lh_mis_data", readDataMem, exp_rdata, 32'h0);
        checkOutput("lh_mis_flag", 32'(misaligned), 32'(exp_mis), 32'h1);

        // Stall for three cycles, then release.
        doOp(1, 0, 2'd2, 0, 32'h10, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            doOp(0, 1, 2'd2, 0, 32'h10, 32'h55AA55AA, 1, 0);
            checkOutput("stall_hold", readDataMem, exp_rdata, 32'hAB345678);
        end
        doOp(0, 1, 2'd2, 0, 32'h10, 32'h55AA55AA, 0, 0);
        doOp(1, 0, 2'd2, 0, 32'h10, 0, 0, 0);
        checkOutput("stall_release", readDataMem, exp_rdata, 32'h55AA55AA);

        // Flush, and flush together with stall.
        doOp(0, 1, 2'd2, 0, 32'h10, 32'h0BADF00D, 0, 1);
        checkOutput("flush_bubble", 32'(valid_out), 32'(exp_valid), 32'h0);
        doOp(0, 1, 2'd2, 0, 32'h10, 32'h11111111, 1, 1);
        checkOutput("stallflush_bubble", 32'(valid_out), 32'(exp_valid), 32'h0);
        doOp(1, 0, 2'd2, 0, 32'h10, 0, 0, 0);
        checkOutput("flush_dropped", readDataMem, exp_rdata, 32'h55AA55AA);

        // Mid-stream asynchronous reset with arbitrary inputs.
        rst_n = 0;
        #1;
        checkOutput("async_reset_valid", 32'(valid_out), 32'h0, 32'h0);
        checkOutput("async_reset_data", readDataMem, 32'h0, 32'h0);
        applyStimulus();
        rst_n = 1;

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            valid_in     = ($urandom_range(0, 5) != 0);
            MemRead_in   = 1'($urandom);
            MemWrite_in  = 1'($urandom);
            memSize_in   = 2'($urandom);
            memSigned_in = 1'($urandom);
            MemtoReg_in  = 2'($urandom);
            RegWrite_in  = 1'($urandom);
            writeReg_in  = 5'($urandom);
            outAlu_in    = $urandom;
            if ($urandom_range(0, 1) == 0) outAlu_in = outAlu_in & 32'h3F;
            writeData_in = $urandom;
            currentPC_in = $urandom;
            stall        = ($urandom_range(0, 4) == 0);
            flush        = ($urandom_range(0, 9) == 0);
            rst_n        = ($urandom_range(0, 59) != 0);
            applyStimulus();
        end
        rst_n = 1;
        @(negedge clk);
        #1;
        cmp_en = 0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/stage_mem.md
# stage_mem

Memory-access stage of the 5-stage MIPS pipeline together with its MEM/WB pipeline register. It takes the EX/MEM-latched ALU result as a byte address and performs loads and stores against an internal synchronous data RAM with byte, halfword and word access. It registers everything the write-back stage consumes: `MemtoReg`, `readDataMem`, `outAlu` and `currentPC`, plus the register-file write controls. Its outputs connect directly to the inputs of `StageWB`.

## Interface
- `ADDR_WIDTH`, 8: word-address width. The RAM holds 2^ADDR_WIDTH 32-bit words.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `stall`  in  1  holds the MEM/WB register and suppresses stores.
- `flush`  in  1  kills the instruction in MEM and inserts a bubble. Overrides `stall`.
- `valid_in`  in  1  the EX/MEM slot holds a real instruction.
- `MemRead_in`, `MemWrite_in`  in  1 each  load and store requests.
- `memSize_in`  in  2  access size: 00 = byte, 01 = half, 10 or 11 = word.
- `memSigned_in`  in  1  1 = sign-extend a sub-word load, 0 = zero-extend.
- `MemtoReg_in`  in  2  write-back select, passed through.
- `RegWrite_in`  in  1  register write enable.
- `writeReg_in`  in  5  destination register.
- `outAlu_in`  in  32  ALU result and byte address.
- `writeData_in`  in  32  store data, right-justified.
- `currentPC_in`  in  32  PC+4 for JAL, passed through.
- `MemtoReg`  out  2  registered.
- `readDataMem`  out  32  registered load result.
- `outAlu`  out  32  registered.
- `currentPC`  out  32  registered.
- `RegWrite`  out  1  registered.
- `writeReg`  out  5  registered.
- `valid_out`  out  1  registered.
- `misaligned`  out  1  registered alignment-fault flag for the instruction now in WB.

## Operation
- **Addressing**
  - Word index is `outAlu_in[ADDR_WIDTH+1:2]`.
  - Higher address bits are ignored, so addresses wrap modulo RAM size.
  - Byte lanes are little-endian: lane k is bits [8k+7:8k], selected by `outAlu_in[1:0]`.
- **Alignment**
  - A half access is misaligned when `addr[0]=1`.
  - A word access is misaligned when `addr[1:0]≠0`.
  - An access is any `valid_in & (MemRead_in | MemWrite_in)`.
  - A misaligned access suppresses the store, forces the latched `readDataMem=0` and `RegWrite=0`, and latches `misaligned=1`.
- **Store**
  - Executes when `valid_in & MemWrite_in & aligned & !stall & !flush`.
  - Byte store: `writeData_in[7:0]` goes to the addressed lane.
  - Half store: `writeData_in[15:0]` goes to lanes {1,0} or {3,2}.
  - Word store: full 32 bits.
  - Unaddressed lanes are unchanged, enforced through per-lane write enables.
- **Load**
  - The RAM word is read combinationally by index.
  - The lane or halfword is extracted, then sign- or zero-extended per `memSigned_in`.
  - The result is latched into `readDataMem`.
  - When `MemRead_in=0`, `readDataMem` latches 0.
- **MEM/WB register update, per rising edge, in priority order:**
  - `flush`: bubble. `valid_out=0`, `RegWrite=0`, `misaligned=0`, `MemtoReg=0`, all data outputs 0.
  - `stall`: all outputs hold.
  - Otherwise: capture the inputs and the load result. `valid_out=valid_in`. `RegWrite=RegWrite_in & valid_in & !misaligned_now`.
- **RAM**
  - Contents are not reset and are undefined until written.
  - The bench writes before it reads.
- **Reset**
  - `rst_n` low clears every registered output to 0 immediately, without waiting for a clock edge.
  - A store whose edge coincides with reset assertion is not performed.

## Timing
- Latency is one cycle: inputs present in cycle N appear on the outputs after edge N.
- A store is written at edge N. A load in cycle N+1 to the same word returns the new data, with no bypass needed.
- A stalled store is not written. It is written on the first edge where `stall=0`, provided it has not been flushed.
- With `stall` and `flush` both high, the flush wins and the store is dropped.
- A `rst_n` release close to a clock edge is the integrator's responsibility. The block itself has no reset synchroniser.

## Test plan
1. **Reset:** hold `rst_n=0` mid-stream with arbitrary inputs. All outputs read 0 asynchronously, and `valid_out=0`.
2. **Word store and load:**
   - Store word 0x12345678 at address 0x10.
   - Next cycle, load word from 0x10.
   - One cycle later `readDataMem=0x12345678`, `MemtoReg`, `outAlu` and `currentPC` pass through, and `RegWrite=1`.
3. **Byte store and loads:**
   - Store byte with `writeData=0x000000AB` to address 0x13.
   - Signed byte load from 0x13 returns 0xFFFFFFAB.
   - Unsigned byte load from 0x13 returns 0x000000AB.
   - Word load from 0x10 returns 0xAB345678.
4. **Half load:**
   - Signed half load from 0x12 returns 0xFFFFAB34.
   - Unsigned half load from 0x12 returns 0x0000AB34.
   - Address 0x10 + 4·2^ADDR_WIDTH aliases to word 0x10.
5. **Misalignment:**
   - Word store of 0xDEADBEEF to address 0x11: memory unchanged (a word read of 0x10 is still 0xAB345678), `misaligned=1`, `RegWrite=0`.
   - Half load from 0x13: `readDataMem=0`, `misaligned=1`.
6. **Stall and flush:**
   - A store held by `stall` for 3 cycles leaves the outputs frozen, and memory changes only on the release edge.
   - A store with `flush=1` is dropped and the next outputs are a bubble (`valid_out=0`).
   - With `stall=1` and `flush=1` together, the result is a bubble.
